// File: rtl/mem_bus_ctrl.sv
// Memory-stage load/store controller driving a pipelined Wishbone master port.
// Optional bus timeout is compiled in with MEM_TIMEOUT_EN.
module mem_bus_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_ce,
    input  logic            i_load,
    input  logic            i_store,
    input  logic            i_wb_op,
    input  logic [2:0]      i_funct3,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_wdata,
    output logic            o_stall,
    output logic            o_done,
    output logic [DW-1:0]   o_rdata,
    output logic            o_rd_we,
    output logic            o_misalign,
    output logic            o_err,
    output logic            o_cyc,
    output logic            o_stb,
    output logic            o_we,
    output logic [AW-1:0]   o_adr,
    output logic [DW-1:0]   o_dat,
    output logic [DW/8-1:0] o_sel,
    input  logic            i_ack,
    input  logic            i_stall,
    input  logic [DW-1:0]   i_dat
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam logic [AW-1:0] LANE_MASK = AW'(NB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    function automatic logic [NB-1:0] lane_sel(input logic [1:0] sz, input logic [OW-1:0] off);
        logic [7:0] base;
        case (sz)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return NB'(base) << off;
    endfunction

    // Doubleword only exists on a 64-bit bus; otherwise alignment is checked on the low address bits.
    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] lo);
        logic [2:0] amask;
        case (sz)
            2'b00:   amask = 3'b000;
            2'b01:   amask = 3'b001;
            2'b10:   amask = 3'b011;
            default: amask = 3'b111;
        endcase
        return ((sz == 2'b11) && (DW != 64)) || ((lo & amask) != 3'b000);
    endfunction

    function automatic logic [DW-1:0] replicate(input logic [DW-1:0] wdata, input logic [1:0] sz);
        logic [DW-1:0] r;
        int span;
        int idx;
        case (sz)
            2'b00:   span = 32'sd1;
            2'b01:   span = 32'sd2;
            2'b10:   span = 32'sd4;
            default: span = 32'sd8;
        endcase
        r = '0;
        for (int i = 0; i < NB; i++) begin
            idx = i % span;
            r[8*i +: 8] = wdata[8*idx +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] raw, input logic [2:0] f3,
                                               input logic [OW-1:0] off);
        logic [DW-1:0] sh;
        int nbits;
        logic fill;
        sh = raw >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   nbits = 32'sd8;
            2'b01:   nbits = 32'sd16;
            2'b10:   nbits = 32'sd32;
            default: nbits = DW;
        endcase
        fill = f3[2] ? 1'b0 : sh[nbits-1];
        for (int i = 0; i < DW; i++) begin
            sh[i] = (i >= nbits) ? fill : sh[i];
        end
        return sh;
    endfunction

    state_t           state_q, state_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic [NB-1:0]    sel_q, sel_d;
    logic             we_q, we_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             rd_we_q, rd_we_d;
    logic             misalign_q, misalign_d;
    logic [OW-1:0]    off_q, off_d;
    logic [2:0]       f3_q, f3_d;
    logic             ack_s;
    logic             adv_s;
    logic             misalign_s;
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    assign misalign_s = misaligned(i_funct3[1:0], i_addr[2:0]);
    assign ack_s      = i_ack && ((state_q == ST_WAIT) || ((state_q == ST_REQ) && !i_stall));
    assign adv_s      = (state_q == ST_REQ) && !i_stall;
    assign o_stall    = (state_q != ST_IDLE);

    // Next-state and registered-output computation for the bus FSM.
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        off_d      = off_q;
        f3_d       = f3_q;
        done_d     = 1'b0;
        rd_we_d    = 1'b0;
        misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_ce) begin
                    if (i_store || i_load) begin
                        if (misalign_s) begin
                            misalign_d = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                            adr_d   = i_addr & ~LANE_MASK;
                            dat_d   = replicate(i_wdata, i_funct3[1:0]);
                            sel_d   = lane_sel(i_funct3[1:0], i_addr[OW-1:0]);
                            we_d    = i_store;
                            off_d   = i_addr[OW-1:0];
                            f3_d    = i_funct3;
`ifdef MEM_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end else if (i_wb_op) begin
                        rd_we_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (ack_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = load_ext(i_dat, f3_q, off_q);
                        rd_we_d = 1'b1;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = adv_s ? ST_WAIT : state_q;
                end
`else
                else begin
                    state_d = adv_s ? ST_WAIT : state_q;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cyc_d = (state_d != ST_IDLE);
        stb_d = (state_d == ST_REQ);
    end

    // State and output registers; reset clears everything even mid-transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            rd_we_q    <= 1'b0;
            misalign_q <= 1'b0;
            off_q      <= '0;
            f3_q       <= 3'b000;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            rd_we_q    <= rd_we_d;
            misalign_q <= misalign_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign o_adr      = adr_q;
    assign o_dat      = dat_q;
    assign o_sel      = sel_q;
    assign o_we       = we_q;
    assign o_cyc      = cyc_q;
    assign o_stb      = stb_q;
    assign o_rdata    = rdata_q;
    assign o_done     = done_q;
    assign o_rd_we    = rd_we_q;
    assign o_misalign = misalign_q;
`ifdef MEM_TIMEOUT_EN
    assign o_err      = err_q;
`else
    assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized self-checking bench for mem_bus_ctrl (DW=32) with a behavioural
// load/store model and a scripted Wishbone slave.
module tb_mem_bus_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_ce, i_load, i_store, i_wb_op;
    logic [2:0]    i_funct3;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic          o_stall, o_done, o_rd_we, o_misalign, o_err;
    logic [DW-1:0] o_rdata;
    logic          o_cyc, o_stb, o_we;
    logic [AW-1:0] o_adr;
    logic [DW-1:0] o_dat;
    logic [3:0]    o_sel;
    logic          i_ack, i_stall;
    logic [DW-1:0] i_dat;

    int            n_checks = 0;
    int            n_errs   = 0;
    logic [31:0]   model_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ce(i_ce), .i_load(i_load), .i_store(i_store), .i_wb_op(i_wb_op),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata), .o_rd_we(o_rd_we),
        .o_misalign(o_misalign), .o_err(o_err),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_adr(o_adr), .o_dat(o_dat),
        .o_sel(o_sel), .i_ack(i_ack), .i_stall(i_stall), .i_dat(i_dat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_ce = 1'b0; i_load = 1'b0; i_store = 1'b0; i_wb_op = 1'b0;
        i_funct3 = 3'd0; i_addr = 32'h0; i_wdata = 32'h0;
    endtask

    function automatic logic [31:0] exp_sel(input logic [2:0] f3, input logic [31:0] addr);
        int size = 1 << f3[1:0];
        return ((32'd1 << size) - 32'd1) << (addr % 4);
    endfunction

    function automatic logic [31:0] exp_wdat(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {24'h0, wd[7:0]} * 32'h0101_0101;
            2'b01:   return {16'h0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdat);
        int nbits = 8 << f3[1:0];
        logic [63:0] v = 64'(rdat >> (8 * (addr % 4)));
        logic [63:0] mask = (64'd1 << nbits) - 64'd1;
        v = v & mask;
        if (!f3[2] && v[nbits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One MEM-stage op followed by the slave response; nwait=0 acks in the accepting cycle.
    task automatic run_op(input logic ld, input logic st, input logic wb, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int nstall, input int nwait, input logic [31:0] rdat);
        logic is_mem = ld || st;
        logic is_ld  = ld && !st;
        int   size   = 1 << f3[1:0];
        logic mis    = (f3[1:0] == 2'b11) || ((addr % size) != 0);
        logic [31:0] ea = addr & 32'hFFFF_FFFC;
        i_ce = 1'b1; i_load = ld; i_store = st; i_wb_op = wb;
        i_funct3 = f3; i_addr = addr; i_wdata = wd;
        i_stall = (nstall > 0); i_ack = 1'b0; i_dat = 32'h0;
        step();
        if (!is_mem) begin
            idle_inputs();
            chk("wb_rd_we", o_rd_we, 1'b1);
            chk("wb_no_cyc", o_cyc, 1'b0);
            chk("wb_rdata_hold", o_rdata, model_rdata);
            step();
            chk("wb_rd_we_pulse", o_rd_we, 1'b0);
        end else if (mis) begin
            idle_inputs();
            chk("mis_pulse", o_misalign, 1'b1);
            chk("mis_no_cyc", o_cyc, 1'b0);
            chk("mis_no_stall", o_stall, 1'b0);
            step();
            chk("mis_pulse_end", o_misalign, 1'b0);
            chk("mis_no_cyc2", o_cyc, 1'b0);
        end else begin
            chk("req_cyc", o_cyc, 1'b1);
            chk("req_stb", o_stb, 1'b1);
            chk("req_stall", o_stall, 1'b1);
            chk("req_adr", o_adr, ea);
            chk("req_we", o_we, st);
            chk("req_sel", o_sel, exp_sel(f3, addr));
            if (st) chk("req_dat", o_dat, exp_wdat(f3, wd));
            // A competing op held during the stall must be ignored.
            i_store = 1'b1; i_load = 1'b0; i_addr = addr ^ 32'h0000_0040;
            for (int k = 0; k < nstall; k++) begin
                step();
                chk("stall_stb", o_stb, 1'b1);
                chk("stall_adr", o_adr, ea);
            end
            i_stall = 1'b0; i_ack = (nwait == 0); i_dat = rdat;
            step();
            if (nwait > 0) begin
                chk("wait_stb", o_stb, 1'b0);
                chk("wait_cyc", o_cyc, 1'b1);
                chk("wait_stall", o_stall, 1'b1);
                for (int k = 1; k < nwait; k++) begin
                    step();
                    chk("wait_no_done", o_done, 1'b0);
                end
                i_ack = 1'b1;
                step();
            end
            i_ack = 1'b0;
            idle_inputs();
            chk("done", o_done, 1'b1);
            chk("done_cyc", o_cyc, 1'b0);
            chk("done_stall", o_stall, 1'b0);
            chk("done_rd_we", o_rd_we, is_ld);
            if (is_ld) model_rdata = exp_load(f3, addr, rdat);
            chk("done_rdata", o_rdata, model_rdata);
            step();
            chk("done_pulse", o_done, 1'b0);
            chk("rd_we_pulse", o_rd_we, 1'b0);
            chk("idle_cyc", o_cyc, 1'b0);
        end
    endtask

    initial begin
        int err_cyc;
        logic seen_done;
        rst_n = 1'b0; i_ack = 1'b0; i_stall = 1'b0; i_dat = 32'h0;
        idle_inputs();
        repeat (3) step();
        chk("rst_cyc", o_cyc, 1'b0);
        chk("rst_stb", o_stb, 1'b0);
        chk("rst_stall", o_stall, 1'b0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_err", o_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h104, 32'hDEAD_BEEF, 0, 1, 32'h0);
        run_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF_FFFF);
        chk("lb_value", o_rdata, 32'hFFFF_FF80);
        run_op(1'b1, 1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FF_FFFF);
        chk("lbu_value", o_rdata, 32'h0000_0080);
        run_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h101, 32'h1234, 0, 1, 32'h0);
        run_op(1'b1, 1'b0, 1'b0, 3'b010, 32'h200, 32'h0, 3, 2, 32'hCAFE_F00D);
        run_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0);
        run_op(1'b1, 1'b1, 1'b1, 3'b000, 32'h202, 32'hA5, 1, 0, 32'h0);

        for (int n = 0; n < 150; n++) begin
            int kind = $urandom_range(0, 5);
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            logic [31:0] addr = $urandom();
            if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            case (kind)
                0: run_op(1'b1, 1'b0, 1'b0, f3, addr, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom());
                1: run_op(1'b0, 1'b1, 1'b0, f3, addr, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom());
                2: run_op(1'b1, 1'b1, 1'b0, f3, addr, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom());
                3: run_op(1'b0, 1'b0, 1'b1, f3, addr, $urandom(), 0, 0, $urandom());
                4: run_op(1'b1, 1'b0, 1'b1, f3, addr, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom());
                default: begin
                    i_ce = 1'b0; i_load = 1'b1; i_store = 1'($urandom_range(0, 1));
                    i_wb_op = 1'b1; i_funct3 = f3; i_addr = addr;
                    step();
                    idle_inputs();
                    chk("noce_cyc", o_cyc, 1'b0);
                    chk("noce_rd_we", o_rd_we, 1'b0);
                    chk("noce_mis", o_misalign, 1'b0);
                end
            endcase
        end

        // Bus never answers.
        i_ce = 1'b1; i_load = 1'b1; i_funct3 = 3'b010; i_addr = 32'h300;
        i_stall = 1'b0; i_ack = 1'b0;
        step();
        idle_inputs();
        err_cyc = -1;
        seen_done = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= 40 && err_cyc < 0; k++) begin
            step();
            if (o_done) seen_done = 1'b1;
            if (o_err) err_cyc = k;
        end
        chk("to_cycle", 64'(err_cyc), 64'(15));
        chk("to_cyc_drop", o_cyc, 1'b0);
        chk("to_no_done", seen_done, 1'b0);
        step();
        chk("to_err_pulse", o_err, 1'b0);
`else
        for (int k = 1; k <= 30; k++) begin
            step();
            if (o_done || o_err) seen_done = 1'b1;
        end
        chk("nto_cyc_held", o_cyc, 1'b1);
        chk("nto_no_end", seen_done, 1'b0);
        i_ack = 1'b1; i_dat = 32'h0BAD_CAFE;
        step();
        i_ack = 1'b0;
        chk("nto_done", o_done, 1'b1);
        model_rdata = 32'h0BAD_CAFE;
        chk("nto_rdata", o_rdata, model_rdata);
        step();
`endif

        // Reset in WAIT, with a stray ack in the first cycle after release.
        i_ce = 1'b1; i_load = 1'b1; i_funct3 = 3'b010; i_addr = 32'h400;
        step();
        idle_inputs();
        step();
        chk("mid_wait_cyc", o_cyc, 1'b1);
        rst_n = 1'b0;
        #1;
        model_rdata = 32'h0;
        chk("mid_rst_cyc", o_cyc, 1'b0);
        chk("mid_rst_stb", o_stb, 1'b0);
        chk("mid_rst_stall", o_stall, 1'b0);
        chk("mid_rst_adr", o_adr, 32'h0);
        chk("mid_rst_sel", o_sel, 4'h0);
        chk("mid_rst_rdata", o_rdata, model_rdata);
        chk("mid_rst_err", o_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        i_ack = 1'b1; i_dat = 32'hFFFF_FFFF;
        step();
        i_ack = 1'b0;
        chk("post_rst_done", o_done, 1'b0);
        chk("post_rst_rd_we", o_rd_we, 1'b0);
        chk("post_rst_cyc", o_cyc, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameters: AW, default 32, bus address width; DW, default 32, data width in bits (32 or 64); TIMEOUT, default 15, max cycles waiting for ack (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 SHALL have ports: i_ce in 1 MEM-stage op valid; i_load in 1 load op; i_store in 1 store op; i_wb_op in 1 op writes rd (R/I/JAL/JALR/LUI/AUIPC); i_funct3 in 3 size/sign code.
REQ-004 SHALL have ports: i_addr in AW byte address; i_wdata in DW store data (LSB-aligned); o_stall out 1 pipeline hold; o_done out 1 load/store completed; o_rdata out DW extended load data; o_rd_we out 1 register-write strobe.
REQ-005 SHALL have ports: o_misalign out 1 misaligned access pulse; o_err out 1 bus timeout pulse.
REQ-006 SHALL have Wishbone-classic-pipelined ports: o_cyc, o_stb, o_we out 1; o_adr out AW; o_dat out DW; o_sel out DW/8; i_ack in 1; i_stall in 1; i_dat in DW.

Function
REQ-007 SHALL implement FSM IDLE, REQ, WAIT.
REQ-008 SHALL accept an op only when i_ce=1 and o_stall=0; ops with i_ce=0 or presented while o_stall=1 SHALL be ignored.
REQ-009 SHALL, on accepted i_load or i_store, register o_adr (aligned down to DW/8 bytes), o_dat, o_sel, o_we=i_store, and move IDLE->REQ with o_cyc=o_stb=1 on the next cycle.
REQ-010 SHALL give i_store priority over i_load if both are set; i_wb_op SHALL be ignored when either is set.
REQ-011 SHALL size by funct3[1:0]: 00 byte, 01 half, 10 word, 11 doubleword (DW=64 only, else treated as misaligned); o_sel SHALL select the addressed lanes; o_dat SHALL replicate store data into those lanes.
REQ-012 SHALL, for a misaligned access (addr not multiple of size), issue no bus cycle, pulse o_misalign one cycle after acceptance, and stay IDLE.
REQ-013 SHALL, in REQ, hold o_stb=1 while i_stall=1; on i_stall=0 SHALL move to WAIT with o_stb=0, o_cyc=1.
REQ-014 SHALL, on i_ack in WAIT (or in REQ when the cycle is accepted the same clock), drop o_cyc, pulse o_done, return to IDLE; for loads capture i_dat lanes, right-shift, sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) into o_rdata and pulse o_rd_we with o_done.
REQ-015 SHALL ignore i_ack in IDLE.
REQ-016 SHALL drive o_stall=1 combinationally whenever state is not IDLE.
REQ-017 SHALL pulse o_rd_we for one cycle, one cycle after an accepted i_wb_op with no load/store; o_rdata SHALL hold its last value.
REQ-018 SHALL make o_done, o_rd_we, o_misalign, o_err single-cycle pulses.

Reset
REQ-019 SHALL, on rst_n=0, immediately force state IDLE and all outputs (o_cyc, o_stb, o_we, o_adr, o_dat, o_sel, o_rdata, o_done, o_rd_we, o_misalign, o_err) to 0, including mid-transaction.
REQ-020 SHALL ignore any i_ack arriving in the first cycle after reset release.

Configuration
REQ-021 SHALL, with macro MEM_TIMEOUT_EN defined, count cycles in REQ/WAIT; when the count reaches TIMEOUT without i_ack, drop o_cyc/o_stb, pulse o_err, emit no o_done/o_rd_we, and return to IDLE; counter SHALL clear on entering REQ.
REQ-022 SHALL, without MEM_TIMEOUT_EN, wait indefinitely for i_ack, tie o_err to 0, and contain no counter.

Verification
REQ-023 SHALL cover sw addr 0x104 data 0xDEADBEEF, i_stall=0, ack on cycle 2 -> o_sel=1111, o_we=1, o_adr=0x104, o_done one pulse, o_stall high 2 cycles.
REQ-024 SHALL cover lb addr 0x103, i_dat=0x80FF_FFFF -> o_sel=1000, o_rdata=0xFFFFFF80, o_rd_we pulse; lbu same -> 0x00000080.
REQ-025 SHALL cover sh addr 0x101 -> no o_cyc, o_misalign one pulse, o_stall stays 0.
REQ-026 SHALL cover lw with i_stall=1 for 3 cycles -> o_stb held 3 cycles then drops, o_cyc held until ack, second i_ce during stall ignored.
REQ-027 SHALL cover MEM_TIMEOUT_EN, TIMEOUT=15, no ack -> o_err pulse at cycle 15, o_cyc=0, no o_done; rst_n low mid-WAIT -> all outputs 0 immediately.
REQ-028 SHALL cover i_wb_op accepted -> o_rd_we pulse next cycle, no o_cyc.
